// File: rtl/regfile_wport_arbiter_pkg.sv
// rtl/regfile_wport_arbiter_pkg.sv - shared register file widths and write-port arbiter encodings
package regfile_wport_arbiter_pkg;

    localparam int RegAddrW    = 5;
    localparam int RegW        = 32;
    localparam int RegNum      = 32;
    localparam logic [RegW-1:0] ZeroWord = '0;
    localparam logic WriteEnable = 1'b1;
    localparam logic RstEnable   = 1'b1;
    localparam int ClrLastAddr = 31;

    typedef enum logic {
        ArbState = 1'b0,
        ClrState = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first valid requester at or after ptr
module rr_picker #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   winner,
    output logic            any
);

    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req_valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - round-robin share of the register file write port with bulk clear
module regfile_wport_arbiter
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = RegAddrW,
    parameter int DW   = RegW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic                    clr_start,
    output logic                    clr_busy,
    output logic                    clr_done,
    output logic                    we,
    output logic [AW-1:0]           waddr,
    output logic [DW-1:0]           wdata,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int IW = $clog2(NREQ);

    arb_state_e    state, state_next;
    logic [IW-1:0] ptr;
    logic [AW-1:0] cnt;
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          hs;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [IW-1:0] ptr_next;
    logic          clr_last;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .winner    (pick_idx),
        .any       (pick_any)
    );

    assign sel_addr = req_addr[int'(pick_idx)*AW +: AW];
    assign sel_data = req_data[int'(pick_idx)*DW +: DW];
    assign ptr_next = (pick_idx == IW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
    assign clr_last = (cnt == AW'(ClrLastAddr));
    assign clr_busy = (state == ClrState);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ArbState;
        end else begin
            state <= state_next;
        end
    end

    // A clear request outranks any pending writeback in the same cycle.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        hs         = 1'b0;
        case (state)
            ArbState: begin
                if (clr_start) begin
                    state_next = ClrState;
                end else begin
                    req_ready = pick_grant;
                    hs        = pick_any;
                end
            end
            ClrState: begin
                if (clr_last) begin
                    state_next = ArbState;
                end
            end
            default: state_next = ArbState;
        endcase
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            cnt      <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= ZeroWord;
            grant_id <= '0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                ArbState: begin
                    we <= 1'b0;
                    if (clr_start) begin
                        cnt <= AW'(1);
                    end else if (hs) begin
                        ptr      <= ptr_next;
                        grant_id <= pick_idx;
                        // Register 0 is hardwired; accept the request but never write it.
                        if (sel_addr != '0) begin
                            we    <= WriteEnable;
                            waddr <= sel_addr;
                            wdata <= sel_data;
                        end
                    end
                end
                ClrState: begin
                    we    <= WriteEnable;
                    waddr <= cnt;
                    wdata <= ZeroWord;
                    if (clr_last) begin
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb/tb_regfile_wport_arbiter.sv - scoreboard bench for the register file write-port arbiter
module tb_regfile_wport_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    gid;
        bit            chk_gid;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [AW-1:0]   a [NREQ];
    logic [DW-1:0]   d [NREQ];
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic            clr_start = 1'b0;
    logic            clr_busy, clr_done, we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic [1:0]      grant_id;

    int  n_chk  = 0;
    int  n_fail = 0;
    wr_t sbq[$];
    wr_t mon_e;
    int  rr_exp[6] = '{0, 1, 2, 0, 1, 2};

    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    regfile_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push(input logic [AW-1:0] ad, input logic [DW-1:0] dt,
                        input logic [1:0] g, input bit cg);
        wr_t e;
        e.addr = ad; e.data = dt; e.gid = g; e.chk_gid = cg;
        sbq.push_back(e);
    endtask

    // Every write seen on the port must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && we) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write actual=%0d required=none", waddr);
            end else begin
                mon_e = sbq.pop_front();
                chk("port_waddr", 64'(waddr), 64'(mon_e.addr));
                chk("port_wdata", 64'(wdata), 64'(mon_e.data));
                if (mon_e.chk_gid) chk("port_grant_id", 64'(grant_id), 64'(mon_e.gid));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            a[i] = AW'(8 + i);
            d[i] = 32'hA0 + i;
        end
        smp();
        chk("rst_we", 64'(we), 0);
        chk("rst_waddr", 64'(waddr), 0);
        chk("rst_wdata", 64'(wdata), 0);
        chk("rst_grant_id", 64'(grant_id), 0);
        chk("rst_clr_busy", 64'(clr_busy), 0);
        chk("rst_clr_done", 64'(clr_done), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        cyc();
        rst = 1'b0;

        // Round robin with all requesters valid from reset
        cyc();
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("rr_ready", 64'(req_ready), 64'(1 << rr_exp[k]));
            push(AW'(8 + rr_exp[k]), 32'hA0 + rr_exp[k], 2'(rr_exp[k]), 1'b1);
            cyc();
        end
        req_valid = '0;

        // Single requester
        a[1] = 5'd5;
        d[1] = 32'hDEADBEEF;
        req_valid = 3'b010;
        smp();
        chk("single_ready", 64'(req_ready), 64'b010);
        push(5'd5, 32'hDEADBEEF, 2'd1, 1'b1);
        cyc();
        req_valid = '0;

        // Address 0: handshake, no write, pointer advances
        cyc();
        a[0] = 5'd0;
        d[0] = 32'h1234;
        req_valid = 3'b001;
        smp();
        chk("addr0_ready", 64'(req_ready), 64'b001);
        cyc();
        a[0] = 5'd7;
        d[0] = 32'h7777;
        req_valid = 3'b011;
        smp();
        chk("addr0_we", 64'(we), 0);
        chk("addr0_next_ready", 64'(req_ready), 64'b010);
        push(5'd5, 32'hDEADBEEF, 2'd1, 1'b1);
        cyc();
        req_valid = 3'b001;
        smp();
        chk("addr0_req0_ready", 64'(req_ready), 64'b001);
        push(5'd7, 32'h7777, 2'd0, 1'b1);

        // Clear with requester 2 contending
        cyc();
        req_valid = 3'b100;
        a[2] = 5'd3;
        d[2] = 32'h55;
        clr_start = 1'b1;
        smp();
        chk("clr_c_ready", 64'(req_ready), 0);
        for (int r = 1; r <= 31; r++) push(AW'(r), 32'h0, 2'd0, 1'b0);
        for (int k = 1; k <= 31; k++) begin
            cyc();
            clr_start = 1'b0;
            smp();
            chk("clr_ready", 64'(req_ready), 0);
            chk("clr_busy", 64'(clr_busy), 1);
            chk("clr_done_early", 64'(clr_done), 0);
        end
        cyc();
        smp();
        chk("clr_end_busy", 64'(clr_busy), 0);
        chk("clr_end_done", 64'(clr_done), 1);
        chk("clr_end_ready", 64'(req_ready), 64'b100);
        push(5'd3, 32'h55, 2'd2, 1'b1);
        cyc();
        req_valid = '0;
        smp();
        chk("clr_done_pulse", 64'(clr_done), 0);

        // Reset in the middle of a clear
        cyc();
        clr_start = 1'b1;
        smp();
        for (int r = 1; r <= 10; r++) push(AW'(r), 32'h0, 2'd0, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            cyc();
            clr_start = 1'b0;
            smp();
            chk("midclr_done", 64'(clr_done), 0);
        end
        #1;
        chk("midclr_waddr", 64'(waddr), 10);
        rst = 1'b1;
        #1;
        chk("midrst_we", 64'(we), 0);
        chk("midrst_waddr", 64'(waddr), 0);
        chk("midrst_wdata", 64'(wdata), 0);
        chk("midrst_grant_id", 64'(grant_id), 0);
        chk("midrst_clr_busy", 64'(clr_busy), 0);
        chk("midrst_clr_done", 64'(clr_done), 0);
        chk("midrst_req_ready", 64'(req_ready), 0);
        cyc();
        rst = 1'b0;
        cyc();
        a[0] = 5'd9;
        d[0] = 32'h77;
        req_valid = 3'b001;
        smp();
        chk("postrst_ready", 64'(req_ready), 64'b001);
        chk("postrst_done", 64'(clr_done), 0);
        push(5'd9, 32'h77, 2'd0, 1'b1);
        cyc();
        req_valid = '0;
        smp();
        chk("postrst_done2", 64'(clr_done), 0);
        repeat (3) cyc();
        chk("sb_drained", 64'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
